// File: rtl/p1p2_seq_gen.sv
// rtl/p1p2_seq_gen.sv - one-hot P1/P2 symbol sequence player with start/busy/done handshake (optional P1P2_SEQ_LOOP_EN)
module p1p2_seq_gen #(
    parameter int             LEN  = 6,
    parameter logic [LEN-1:0] SEQ  = 6'b010000,
    parameter int             HOLD = 1,
    parameter int             GAP  = 0,
    localparam int            IW   = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
`ifdef P1P2_SEQ_LOOP_EN
    input  logic          loop_mode,
`endif
    output logic          P1,
    output logic          P2,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] idx
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int GW = ($clog2(GAP + 1) > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [IW-1:0] IDX_LAST  = IW'(LEN - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          p1_q, p1_d;
    logic          p2_q, p2_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          loop_w;

`ifdef P1P2_SEQ_LOOP_EN
    assign loop_w = loop_mode;
`else
    assign loop_w = 1'b0;
`endif

    // State, counters and registered outputs; reset returns everything to idle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
            p1_q    <= 1'b0;
            p2_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so they register in step with it
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                idx_d  = '0;
                hold_d = '0;
                gap_d  = '0;
                if (start && !abort) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    hold_d  = '0;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HW'(1);
                end else begin
                    hold_d = '0;
                    if (idx_q != IDX_LAST) begin
                        if (GAP > 0) begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else if (loop_w) begin
                        // Loop restart: flag end of pass but stay busy
                        done_d = 1'b1;
                        if (GAP > 0) begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end else begin
                            idx_d = '0;
                        end
                    end else begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    gap_d   = '0;
                end else if (gap_q != GAP_LAST) begin
                    gap_d = gap_q + GW'(1);
                end else begin
                    state_d = S_EMIT;
                    gap_d   = '0;
                    // A gap after the last symbol only occurs when looping
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
        p1_d   = (state_d == S_EMIT) && !SEQ[idx_d];
        p2_d   = (state_d == S_EMIT) && SEQ[idx_d];
        busy_d = (state_d == S_EMIT) || (state_d == S_GAP);
        done_d = done_d || (state_d == S_DONE);
    end

    assign P1   = p1_q;
    assign P2   = p2_q;
    assign busy = busy_q;
    assign done = done_q;
    assign idx  = idx_q;

endmodule

// File: tb/tb_p1p2_seq_gen.sv
// tb/tb_p1p2_seq_gen.sv - scoreboard bench for p1p2_seq_gen (default and HOLD=2/GAP=1 instances)
module tb_p1p2_seq_gen;

    localparam logic [5:0] SEQV = 6'b010000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_a = 1'b0, abort_a = 1'b0;
    logic       start_b = 1'b0, abort_b = 1'b0;
    logic       loop_a = 1'b0;
    logic       p1_a, p2_a, busy_a, done_a;
    logic       p1_b, p2_b, busy_b, done_b;
    logic [2:0] idx_a, idx_b;

    int total = 0;
    int bad   = 0;
    string tag = "init";

    typedef struct {
        logic       u;
        logic [7:0] v;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    p1p2_seq_gen dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
`ifdef P1P2_SEQ_LOOP_EN
        .loop_mode(loop_a),
`endif
        .P1(p1_a), .P2(p2_a), .busy(busy_a), .done(done_a), .idx(idx_a)
    );

    p1p2_seq_gen #(.HOLD(2), .GAP(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
`ifdef P1P2_SEQ_LOOP_EN
        .loop_mode(1'b0),
`endif
        .P1(p1_b), .P2(p2_b), .busy(busy_b), .done(done_b), .idx(idx_b)
    );

    function automatic logic [7:0] pack(logic p1, logic p2, logic bz, logic dn, logic [2:0] ix);
        return {p1, p2, bz, dn, 1'b0, ix};
    endfunction

    task automatic push(logic u, logic p1, logic p2, logic bz, logic dn, logic [2:0] ix);
        exp_t e;
        e.u = u;
        e.v = pack(p1, p2, bz, dn, ix);
        q.push_back(e);
    endtask

    task automatic push_idle(logic u, int n);
        for (int i = 0; i < n; i++) push(u, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    // Expected cycle-by-cycle output of a normal single-shot playback
    task automatic push_run(logic u, int hold, int gap);
        for (int i = 0; i < 6; i++) begin
            for (int h = 0; h < hold; h++) push(u, ~SEQV[i], SEQV[i], 1'b1, 1'b0, 3'(i));
            if (i < 5) for (int g = 0; g < gap; g++) push(u, 1'b0, 1'b0, 1'b1, 1'b0, 3'(i));
        end
        push(u, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        push_idle(u, 1);
    endtask

    // Advance one cycle, sample #1 after the edge, compare against the scoreboard head
    task automatic cyc();
        exp_t e;
        logic [7:0] obs;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            obs = e.u ? pack(p1_b, p2_b, busy_b, done_b, idx_b)
                      : pack(p1_a, p2_a, busy_a, done_a, idx_a);
            total++;
            assert (obs === e.v)
            else begin
                bad++;
                $error("FAIL %s obs={p1,p2,busy,done,0,idx}=%b exp=%b", tag, obs, e.v);
            end
        end
        if ((p1_a & p2_a) | (p1_b & p2_b)) begin
            bad++;
            $error("FAIL %s onehot P1 and P2 both high", tag);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() > 0 && guard < 200) begin
            cyc();
            guard++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $error("FAIL %s timeout remaining=%0d exp=0", tag, q.size());
            q.delete();
        end
    endtask

    initial begin
        // 1: reset state, then quiet idle
        tag = "reset";
        push_idle(1'b0, 1);
        push_idle(1'b1, 1);
        cyc();
        cyc();
        reset = 1'b0;
        tag = "idle";
        push_idle(1'b0, 5);
        drain();

        // 2: default playback
        tag = "default";
        start_a = 1'b1;
        push_run(1'b0, 1, 0);
        cyc();
        start_a = 1'b0;
        drain();

        // 3: HOLD=2 GAP=1 playback
        tag = "hold2gap1";
        start_b = 1'b1;
        push_run(1'b1, 2, 1);
        cyc();
        start_b = 1'b0;
        drain();

        // 4: restart ignored while busy, then abort
        tag = "abort";
        for (int i = 0; i < 4; i++) push(1'b0, ~SEQV[i], SEQV[i], 1'b1, 1'b0, 3'(i));
        push_idle(1'b0, 3);
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        cyc();
        cyc();
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        abort_a = 1'b1;
        cyc();
        abort_a = 1'b0;
        drain();

        // 4b: abort during a gap of the HOLD=2 GAP=1 instance
        tag = "abort_gap";
        push(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
        push(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
        push(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        push_idle(1'b1, 2);
        start_b = 1'b1;
        cyc();
        start_b = 1'b0;
        cyc();
        cyc();
        abort_b = 1'b1;
        cyc();
        abort_b = 1'b0;
        drain();

        // 5: start with abort in idle plays nothing; reset mid-playback
        tag = "start_abort";
        push_idle(1'b0, 3);
        start_a = 1'b1;
        abort_a = 1'b1;
        cyc();
        start_a = 1'b0;
        abort_a = 1'b0;
        drain();
        tag = "reset_mid";
        for (int i = 0; i < 3; i++) push(1'b0, ~SEQV[i], SEQV[i], 1'b1, 1'b0, 3'(i));
        push_idle(1'b0, 3);
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        drain();

`ifdef P1P2_SEQ_LOOP_EN
        // 6: three looped passes, loop dropped during pass 3
        tag = "loop";
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 6; i++)
                push(1'b0, ~SEQV[i], SEQV[i], 1'b1, (p > 0 && i == 0), 3'(i));
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        push_idle(1'b0, 2);
        loop_a = 1'b1;
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        for (int c = 1; c < 14; c++) cyc();
        loop_a = 1'b0;
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
